// File: rtl/pipereg_chain.sv
// Elastic valid/ready pipeline of STAGES register slots with bubble collapse, hold and flush.
// Define PIPEREG_CHAIN_STATS_EN to add the saturating stall_cnt output.
module pipereg_chain #(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 3,
  localparam int unsigned CW    = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          hold,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out,
  output logic [CW-1:0] count
`ifdef PIPEREG_CHAIN_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  logic [STAGES-1:0] valid_q, valid_d, adv;
  logic [N-1:0]      data_q [STAGES];
  logic [N-1:0]      data_d [STAGES];
  logic [CW-1:0]     count_q, count_d;
  logic              room0;
  logic              in_acc;

  assign out_valid = valid_q[STAGES-1] && !hold;
  assign out       = data_q[STAGES-1];
  assign count     = count_q;

  // Advance decisions ripple from the output side so a full chain can move as one.
  always_comb begin
    logic room;
    room = out_ready && !hold;
    adv  = '0;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv[k] = valid_q[k] && room;
      room   = !valid_q[k] || adv[k];
    end
    room0 = room;
  end

  assign in_ready = !reset && !hold && !flush && room0;
  assign in_acc   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = '0;
    if (flush) begin
      valid_d = '0;
      for (int k = 0; k < int'(STAGES); k++) data_d[k] = '0;
    end else if (!hold) begin
      valid_d = valid_q & ~adv;
      if (in_acc) begin
        valid_d[0] = 1'b1;
        data_d[0]  = in;
      end
      for (int k = 1; k < int'(STAGES); k++) begin
        if (adv[k-1]) begin
          valid_d[k] = 1'b1;
          data_d[k]  = data_q[k-1];
        end
      end
    end
    for (int k = 0; k < int'(STAGES); k++) count_d = count_d + CW'(valid_d[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

`ifdef PIPEREG_CHAIN_STATS_EN
  // Cycles where a word waits on the output for a non-ready downstream.
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (valid_q[STAGES-1] && !hold && !out_ready && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`else
  // No stall statistics in this build.
`endif

endmodule

// File: tb/tb_pipereg_chain.sv
// Scoreboard bench for pipereg_chain (N=8, STAGES=3): accepted words are queued and
// compared in order when emitted; the queue depth also serves as the expected count.
module tb_pipereg_chain;
  localparam int unsigned N      = 8;
  localparam int unsigned STAGES = 3;
  localparam int unsigned CW     = $clog2(STAGES + 1);

  logic          clk = 1'b0;
  logic          reset, flush, hold, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  din, dout;
  logic [CW-1:0] count;
`ifdef PIPEREG_CHAIN_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  pipereg_chain #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .hold      (hold),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (dout),
    .count     (count)
`ifdef PIPEREG_CHAIN_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] data;
    int unsigned  cyc;
  } sb_t;

  sb_t         q[$];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc    = 0;
  bit          chk_lat = 1'b0;
  logic        acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Sample at the falling edge: count model, output scoreboard, input capture.
  task automatic settle();
    sb_t e;
    @(negedge clk);
    if (!reset) check("count", 32'(count), 32'(q.size()));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("sb_underflow", 32'(q.size()), 32'(1));
      end else begin
        e = q.pop_front();
        check("out_data", 32'(dout), 32'(e.data));
        if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'(STAGES));
      end
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back('{din, cyc});
    if (reset || flush) q.delete();
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    settle();
    next_edge();
  endtask

  task automatic fill(input logic [N-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      din      = base + N'(i);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && q.size() > 0; i++) tick();
    check("drain_empty", 32'(q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; flush = 1'b0; hold = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; din = '0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      settle();
      check("rst_in_ready", 32'(in_ready), 32'(0));
      next_edge();
    end
    reset = 1'b0; in_valid = 1'b0;
    settle();
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out", 32'(dout), 32'(0));
    check("rst_count", 32'(count), 32'(0));
    check("rst_in_ready_after", 32'(in_ready), 32'(1));
    next_edge();

    // Single word latency
    chk_lat = 1'b1; out_ready = 1'b1; in_valid = 1'b1; din = 8'hA5;
    tick();
    in_valid = 1'b0; din = '0;
    for (int c = 1; c <= 4; c++) begin
      settle();
      check("single_out_valid", 32'(out_valid), 32'(c == 3));
      if (c == 3) check("single_out", 32'(dout), 32'h0000_00A5);
      if (c == 4) check("single_count", 32'(count), 32'(0));
      next_edge();
    end

    // Back-to-back stream
    for (int i = 1; i <= 10; i++) begin
      din = 8'(i); in_valid = 1'b1;
      settle();
      check("stream_in_ready", 32'(in_ready), 32'(1));
      next_edge();
    end
    in_valid = 1'b0;
    drain();
    chk_lat = 1'b0;

    // Backpressure: fourth word refused until downstream is ready
    out_ready = 1'b0;
    begin
      int idx = 0;
      for (int c = 0; c < 4; c++) begin
        din = 8'h21 + 8'(idx); in_valid = 1'b1;
        settle();
        if (c == 3) begin
          check("bp_in_ready", 32'(in_ready), 32'(0));
          check("bp_count", 32'(count), 32'(3));
        end
        if (acc) idx++;
        next_edge();
      end
    end
    out_ready = 1'b1;
    settle();
    check("bp_swap_in_ready", 32'(in_ready), 32'(1));
    check("bp_swap_out_valid", 32'(out_valid), 32'(1));
    next_edge();
    in_valid = 1'b0;
    settle();
    check("bp_swap_count", 32'(count), 32'(3));
    next_edge();
    drain();

    // Hold freezes a full chain
    out_ready = 1'b0;
    fill(8'h31, 3);
    out_ready = 1'b1; hold = 1'b1; in_valid = 1'b1; din = 8'h34;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("hold_out_valid", 32'(out_valid), 32'(0));
      check("hold_in_ready", 32'(in_ready), 32'(0));
      check("hold_count", 32'(count), 32'(3));
      check("hold_out", 32'(dout), 32'h0000_0031);
      next_edge();
    end
    hold = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      next_edge();
      if (acc) break;
    end
    in_valid = 1'b0;
    drain();

    // Flush wins over hold and drops the offered word
    out_ready = 1'b0;
    fill(8'h41, 2);
    flush = 1'b1; hold = 1'b1; in_valid = 1'b1; din = 8'h43;
    settle();
    check("flush_in_ready", 32'(in_ready), 32'(0));
    next_edge();
    flush = 1'b0; hold = 1'b0; in_valid = 1'b0;
    settle();
    check("flush_count", 32'(count), 32'(0));
    check("flush_out", 32'(dout), 32'(0));
    check("flush_out_valid", 32'(out_valid), 32'(0));
    next_edge();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      check("flush_no_emit", 32'(out_valid), 32'(0));
      next_edge();
    end

    // Reset mid-stream discards in-flight words
    fill(8'h51, 3);
    reset = 1'b1; in_valid = 1'b1; din = 8'h54;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    settle();
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    next_edge();
    for (int c = 0; c < 4; c++) begin
      settle();
      check("midrst_no_emit", 32'(out_valid), 32'(0));
      next_edge();
    end

`ifdef PIPEREG_CHAIN_STATS_EN
    // Stall counter: counts blocked output cycles, not hold cycles
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("stall_rst", 32'(stall_cnt), 32'(0));
    next_edge();
    out_ready = 1'b0;
    fill(8'h61, 3);
    for (int c = 0; c < 5; c++) tick();
    hold = 1'b1;
    settle();
    check("stall_five", 32'(stall_cnt), 32'(5));
    next_edge();
    tick();
    hold = 1'b0; out_ready = 1'b1;
    settle();
    check("stall_hold", 32'(stall_cnt), 32'(5));
    next_edge();
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipereg_chain.md
PIPEREG_CHAIN -- requirements
Module: pipereg_chain

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the data width in bits (1..256).
REQ-002 The block SHALL have parameter STAGES, default 3, giving the pipeline depth in slots (1..8).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port flush, input, 1, synchronous discard of all held words.
REQ-006 The block SHALL have port hold, input, 1, freezes the whole chain for the cycle.
REQ-007 The block SHALL have port in_valid, input, 1, upstream offers a word.
REQ-008 The block SHALL have port in_ready, output, 1, block accepts the word this cycle.
REQ-009 The block SHALL have port in, input, N, upstream data.
REQ-010 The block SHALL have port out_valid, output, 1, last slot holds a word.
REQ-011 The block SHALL have port out_ready, input, 1, downstream accepts the word this cycle.
REQ-012 The block SHALL have port out, output, N, last-slot data, driven directly from a register.
REQ-013 The block SHALL have port count, output, $clog2(STAGES+1), number of occupied slots.

Function
REQ-014 Slots SHALL be numbered 0 (input side) to STAGES-1 (output side), each with one data register and one valid bit.
REQ-015 A transfer SHALL occur on a port only when valid and ready are both 1 in the same cycle.
REQ-016 Slot k SHALL advance into slot k+1 when slot k+1 is empty or slot k+1 advances in the same cycle (bubble collapse).
REQ-017 The last slot SHALL empty when out_valid=1 and out_ready=1.
REQ-018 in_ready SHALL be !hold && !flush && (slot 0 empty || slot 0 advances); it is combinational from out_ready.
REQ-019 out_valid SHALL be the last-slot valid bit gated low while hold=1.
REQ-020 Into an empty chain, a word accepted at cycle t SHALL appear on out at cycle t+STAGES.
REQ-021 With out_ready held at 1, sustained throughput SHALL be one word per cycle with no bubbles.
REQ-022 While hold=1 (and flush=0), no slot SHALL change, count SHALL stay constant, and no transfer SHALL occur on either port.
REQ-023 While flush=1, all valid bits and all data registers SHALL clear to 0 at the next edge, and the input word SHALL be dropped.
REQ-024 Priority SHALL be reset > flush > hold > normal operation.
REQ-025 When the chain is full and out_ready=1, a simultaneous accept and emit SHALL occur, leaving count at STAGES.
REQ-026 count SHALL equal the popcount of the slot valid bits, and SHALL never exceed STAGES.
REQ-027 Data in empty slots SHALL be don't-care on out while out_valid=0, except after reset or flush, when it SHALL be 0.

Reset
REQ-028 At the edge where reset=1, all valid bits, data registers and count SHALL clear to 0, out_valid SHALL be 0 and out SHALL be 0.
REQ-029 in_ready SHALL be 0 while reset=1, and 1 in the first cycle after reset deasserts (absent hold).
REQ-030 Reset asserted mid-stream SHALL discard all in-flight words with no partial emission.

Configuration
REQ-031 With macro PIPEREG_CHAIN_STATS_EN defined, the block SHALL add port stall_cnt, output, 16, counting cycles where the last slot is valid, hold=0 and out_ready=0; the count SHALL saturate at 0xFFFF and clear only on reset.
REQ-032 Without PIPEREG_CHAIN_STATS_EN, port stall_cnt and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=8, STAGES=3)
REQ-033 Reset, then in_valid=1 with in=0xA5 at cycle 0 and out_ready=1 -> out_valid=1, out=0xA5 at cycle 3, and count returns to 0 at cycle 4.
REQ-034 Stream 0x01..0x0A, one per cycle, with out_ready=1 -> outputs 0x01..0x0A on consecutive cycles starting 3 cycles after the first accept.
REQ-035 out_ready=0 while 4 words are offered -> 3 words accepted, in_ready=0 on the 4th, count=3; then out_ready=1 -> emit and accept in the same cycle, count stays 3.
REQ-036 Full chain, hold=1 for 2 cycles with out_ready=1 -> out_valid=0, in_ready=0, count=3 unchanged; after release, the original order resumes.
REQ-037 Chain holding 2 words, flush=1 together with hold=1 and in_valid=1 -> next cycle count=0, out=0x00, input word lost.
REQ-038 With PIPEREG_CHAIN_STATS_EN, a full chain with out_ready=0 for 5 cycles -> stall_cnt=5; hold=1 cycles do not increment it.
